fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Write-side arbiter for the shared asynchronous FIFO. It collects words from NUM_REQ producers in the write clock domain over valid/ready handshakes. It grants the FIFO write port to one producer at a time, round-robin, with a bounded burst length. It drives the FIFO's write enable and write data and honours the FIFO's full flag.

## Interface
Parameters:
- NUM_REQ, 4: number of producers, ≥2.
- DATA_WIDTH, 8: word width; equals the FIFO DATA_WIDTH.
- MAX_BURST, 4: maximum words transferred per grant, ≥1.
- ID_W, $clog2(NUM_REQ): width of grant_id.

Ports:
- wr_clk  in  1  FIFO write-domain clock; all logic is on its rising edge.
- wr_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-producer word valid.
- req_last  in  NUM_REQ  per-producer end-of-burst marker; qualified by valid.
- req_data  in  NUM_REQ*DATA_WIDTH  per-producer word; producer i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-producer accept.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data.
- fifo_wr_full  in  1  from FIFO wr_full.
- grant_active  out  1  a producer currently holds the grant.
- grant_id  out  ID_W  index of the granted producer.

## Operation
- Two-state FSM: IDLE and BURST. Registers: state, grant_id, rr_ptr (ID_W bits), burst_cnt (counts 0..MAX_BURST-1).
- IDLE:
  - If any req_valid is set, the winner is the first set index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Next cycle: state=BURST, grant_id=winner, burst_cnt=0.
  - No transfer takes place in IDLE; all req_ready are 0.
- BURST with granted index g:
  - req_ready[g] = ~fifo_wr_full; all other ready bits are 0.
  - transfer = req_valid[g] & ~fifo_wr_full.
  - fifo_wr_en = transfer.
  - fifo_wr_data = req_data slice g.
- Release conditions in BURST. Any one of these returns the FSM to IDLE next cycle and sets rr_ptr=(g+1) mod NUM_REQ:
  - (a) a transfer with req_last[g]=1;
  - (b) a transfer while burst_cnt==MAX_BURST-1;
  - (c) req_valid[g]=0 in any BURST cycle (no transfer that cycle).
- On a transfer without release, burst_cnt increments.
- fifo_wr_full=1 with req_valid[g]=1 is a stall: grant is held, burst_cnt is unchanged, no write occurs, and the stall never causes release.
- A producer must hold req_valid, req_data and req_last stable while valid & ~ready. The arbiter does not check this.
- Outside BURST: fifo_wr_en=0, fifo_wr_data=0, req_ready=0, grant_active=0.
- grant_id keeps its last value in IDLE.
- Fairness: after release, the released producer has lowest priority. A waiting producer is granted within NUM_REQ-1 intervening grants.
- MAX_BURST=1: every transfer releases.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - Registers: state=IDLE, grant_id=0, rr_ptr=0, burst_cnt=0.
  - Outputs: fifo_wr_en=0, fifo_wr_data=0, req_ready=0, grant_active=0.
  - Reset mid-burst aborts the burst. Words already written stay in the FIFO. An unaccepted word is not written.

## Timing
- Arbitration latency: req_valid rising in cycle n (FSM in IDLE) gives grant_active=1 and the first possible write in cycle n+1.
- In BURST, ready and fifo_wr_en are combinational from req_valid, fifo_wr_full and registered state. There is no registered output stage; the FIFO samples wr_en/wr_data on the same wr_clk edge.
- One IDLE bubble cycle follows each release.
- Peak throughput: MAX_BURST words per MAX_BURST+1 cycles.
- fifo_wr_full is sampled in the same cycle it is used. The FIFO's own full gating is redundant by design: a write is never attempted while full.

## Test plan
- Reset: assert wr_rst_n=0 mid-burst → outputs immediately 0, state IDLE. Release reset with req_valid=4'b0001 → grant_id=0 one cycle later.
- Round-robin: req_valid=4'b1111 held, req_last=0, MAX_BURST=4, FIFO never full.
  - Grants go 0,1,2,3,0.
  - Each grant carries exactly 4 fifo_wr_en pulses, followed by 1 idle cycle.
  - 16 words in 20 cycles.
- Early last: producer 2 sends 2 words with req_last on the second → release after 2 writes, rr_ptr=3. Next grant goes to producer 3 if it is valid, else the next valid index wrapping.
- Full stall: grant producer 1, assert fifo_wr_full for 5 cycles mid-burst.
  - No writes during the stall; req_ready[1]=0; grant held; burst_cnt frozen.
  - After full drops, the remaining words complete the burst of 4.
- Valid drop: producer 0 granted, writes 1 word, then deasserts valid → release next cycle; burst_cnt does not persist into the next grant.
- Data integrity: 4 producers stream tagged words {id,seq} into a FIFO model with random full → every word appears exactly once, per-producer order is preserved, and no write occurs while fifo_wr_full=1.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and FIFO write-port bundle between producers, the write arbiter and the FIFO.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_W       = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic                          fifo_wr_full;
   logic                          grant_active;
   logic [ID_W-1:0]               grant_id;

   // Environment side: producers plus the FIFO full flag
   modport master (
      output req_valid, req_last, req_data, fifo_wr_full,
      input  req_ready, fifo_wr_en, fifo_wr_data, grant_active, grant_id
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_last, req_data, fifo_wr_full,
      output req_ready, fifo_wr_en, fifo_wr_data, grant_active, grant_id
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter for the shared async FIFO.
// Grants the FIFO write port to one producer at a time for at most MAX_BURST
// words; ready/wr_en are combinational so the FIFO samples on the same edge.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input logic              wr_clk,
   input logic              wr_rst_n,
   fifo_wr_arbiter_if.slave bus
);

   localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BC_W-1:0] LAST_CNT = BC_W'(MAX_BURST - 1);

   typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

   state_t                r_state, w_state_nxt;
   logic [ID_W-1:0]       r_grant_id, w_grant_nxt;
   logic [ID_W-1:0]       r_rr_ptr, w_rr_nxt;
   logic [BC_W-1:0]       r_burst_cnt, w_cnt_nxt;
   logic [ID_W-1:0]       w_winner, w_cand, w_ptr_inc;
   logic                  w_any_valid, w_g_valid, w_g_last, w_xfer;
   logic [NUM_REQ-1:0]    w_ready;
   logic                  w_wr_en;
   logic [DATA_WIDTH-1:0] w_slice, w_wr_data;

   // Round-robin search: first valid index starting at rr_ptr, wrapping
   always_comb begin
      w_winner    = r_rr_ptr;
      w_any_valid = 1'b0;
      w_cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_cand = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
         if (!w_any_valid && bus.req_valid[w_cand]) begin
            w_any_valid = 1'b1;
            w_winner    = w_cand;
         end
      end
   end

   // Select the granted producer's word, valid and last
   always_comb begin
      w_slice = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == ID_W'(i)) w_slice = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      w_g_valid = bus.req_valid[r_grant_id];
      w_g_last  = bus.req_last[r_grant_id];
      w_ptr_inc = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant_id;
      w_rr_nxt    = r_rr_ptr;
      w_cnt_nxt   = r_burst_cnt;
      w_ready     = '0;
      w_wr_en     = 1'b0;
      w_wr_data   = '0;
      w_xfer      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_any_valid) begin
               w_state_nxt = S_BURST;
               w_grant_nxt = w_winner;
               w_cnt_nxt   = '0;
            end
         end
         S_BURST: begin
            w_ready[r_grant_id] = ~bus.fifo_wr_full;
            w_xfer              = w_g_valid & ~bus.fifo_wr_full;
            w_wr_en             = w_xfer;
            w_wr_data           = w_slice;
            // Dropped valid releases; a full stall with valid held never does
            if (!w_g_valid) begin
               w_state_nxt = S_IDLE;
               w_rr_nxt    = w_ptr_inc;
            end else if (w_xfer) begin
               if (w_g_last || (r_burst_cnt == LAST_CNT)) begin
                  w_state_nxt = S_IDLE;
                  w_rr_nxt    = w_ptr_inc;
               end else begin
                  w_cnt_nxt = r_burst_cnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and grant registers
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         r_state     <= S_IDLE;
         r_grant_id  <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant_id  <= w_grant_nxt;
         r_rr_ptr    <= w_rr_nxt;
         r_burst_cnt <= w_cnt_nxt;
      end
   end

   assign bus.req_ready    = w_ready;
   assign bus.fifo_wr_en   = w_wr_en;
   assign bus.fifo_wr_data = w_wr_data;
   assign bus.grant_active = (r_state == S_BURST);
   assign bus.grant_id     = r_grant_id;

endmodule
